control_barra: RTL and testbench

Button front-end for the paddle block. Turns two raw, asynchronous, bouncing push-buttons into clean, mutually exclusive one-cycle `up`/`down` move commands. Each press gives one immediate command, then auto-repeats while the button is held. Sits between the board buttons and the paddle position register; each output pulse moves the paddle exactly one step.

---
 rtl/control_barra.sv | 183 ++++++++++++++++++
 tb/tb_control_barra.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/control_barra.sv
// control_barra: push-button front-end for the paddle block.
//
// Two raw, asynchronous, bouncing buttons are synchronized and debounced.
// The result is resolved into a single direction. A small FSM turns that
// direction into one-cycle move commands: one immediately on a press, then
// auto-repeat while the button stays held.
//
// Ports:
//   clk      - system clock (only clock)
//   reset    - asynchronous, active-low reset
//   btn_up   - raw up button, active-high, asynchronous to clk
//   btn_down - raw down button, active-high, asynchronous to clk
//   up       - registered one-cycle move-up command
//   down     - registered one-cycle move-down command
//
// Parameters (all >= 2 and < 2^24, counters are 24 bits):
//   DEBOUNCE      - consecutive stable cycles needed to accept a level change
//   REPEAT_DELAY  - cycles from the first command to the first auto-repeat
//   REPEAT_PERIOD - cycles between later auto-repeats

module control_barra #(
  parameter int unsigned DEBOUNCE      = 250000,
  parameter int unsigned REPEAT_DELAY  = 7500000,
  parameter int unsigned REPEAT_PERIOD = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic up,
  output logic down
);

  localparam logic [23:0] DB_LAST     = 24'(DEBOUNCE - 1);
  localparam logic [23:0] DELAY_LAST  = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] PERIOD_LAST = 24'(REPEAT_PERIOD - 1);

  // Direction codes; 2'b00 doubles as the reset value of dir.
  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_DOWN = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Index 0 is the up button, index 1 is the down button.
  logic [1:0]  raw;
  logic [1:0]  s1;
  logic [1:0]  s2;
  logic [1:0]  stable;
  logic [23:0] db_cnt [2];

  logic [1:0]  cmd;
  state_t      state;
  state_t      state_next;
  logic [1:0]  dir;
  logic [1:0]  dir_next;
  logic [23:0] tmr;
  logic [23:0] tmr_next;
  logic        up_next;
  logic        down_next;

  assign raw = {btn_down, btn_up};

  // Two-flop synchronizers for both raw buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 2'b00;
      s2 <= 2'b00;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debouncers: a level is accepted only after DEBOUNCE consecutive cycles
  // of disagreement with the current stable value. Any agreement restarts
  // the count, so short glitches never reach the stable value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable    <= 2'b00;
      db_cnt[0] <= 24'd0;
      db_cnt[1] <= 24'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == stable[i]) begin
          db_cnt[i] <= 24'd0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= s2[i];
          db_cnt[i] <= 24'd0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 24'd1;
        end
      end
    end
  end

  // Direction resolve: both held, or neither held, means no motion.
  always_comb begin
    cmd = CMD_NONE;
    if (stable[0] && !stable[1]) begin
      cmd = CMD_UP;
    end else if (stable[1] && !stable[0]) begin
      cmd = CMD_DOWN;
    end else begin
      cmd = CMD_NONE;
    end
  end

  // Command FSM state, latched direction, repeat timer and output pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      dir   <= CMD_NONE;
      tmr   <= 24'd0;
      up    <= 1'b0;
      down  <= 1'b0;
    end else begin
      state <= state_next;
      dir   <= dir_next;
      tmr   <= tmr_next;
      up    <= up_next;
      down  <= down_next;
    end
  end

  // Next-state logic. Any change of resolved direction drops back to IDLE
  // without a pulse, so a swap to the opposite button costs one extra edge
  // and the old direction can never pulse after the change.
  always_comb begin
    state_next = state;
    dir_next   = dir;
    tmr_next   = tmr;
    up_next    = 1'b0;
    down_next  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd != CMD_NONE) begin
          dir_next   = cmd;
          up_next    = (cmd == CMD_UP);
          down_next  = (cmd == CMD_DOWN);
          tmr_next   = 24'd0;
          state_next = DELAY;
        end else begin
          state_next = IDLE;
        end
      end
      DELAY: begin
        if (cmd != dir) begin
          state_next = IDLE;
        end else if (tmr == DELAY_LAST) begin
          up_next    = (dir == CMD_UP);
          down_next  = (dir == CMD_DOWN);
          tmr_next   = 24'd0;
          state_next = REPEAT;
        end else begin
          tmr_next = tmr + 24'd1;
        end
      end
      REPEAT: begin
        if (cmd != dir) begin
          state_next = IDLE;
        end else if (tmr == PERIOD_LAST) begin
          up_next    = (dir == CMD_UP);
          down_next  = (dir == CMD_DOWN);
          tmr_next   = 24'd0;
          state_next = REPEAT;
        end else begin
          tmr_next = tmr + 24'd1;
        end
      end
      default: begin
        state_next = IDLE;
        dir_next   = CMD_NONE;
        tmr_next   = 24'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_barra.sv
// Directed testbench for control_barra with DEBOUNCE=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Edge numbers in each scenario count from the first clock
// edge that samples the new raw button level (edge 0).

module tb_control_barra;

  logic clk;
  logic reset;
  logic btn_up;
  logic btn_down;
  logic up;
  logic down;

  int checks;
  int failures;

  control_barra #(
    .DEBOUNCE      (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .up       (up),
    .down     (down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int edge_no, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_no, obs, exp);
    end
  endtask

  // Quiet cycles with both buttons released; no output may fire.
  task automatic idle(input string tag, input int n);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, i, up, 1'b0);
      chk(tag, i, down, 1'b0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    btn_up   = 1'b1;
    btn_down = 1'b1;

    // 1: reset asserted mid-cycle, before any clock edge, clears outputs.
    #2;
    reset = 1'b0;
    #1;
    chk("t1_async_up", -1, up, 1'b0);
    chk("t1_async_down", -1, down, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_hold_up", i, up, 1'b0);
      chk("t1_hold_down", i, down, 1'b0);
    end
    btn_up   = 1'b0;
    btn_down = 1'b0;
    reset    = 1'b1;
    idle("t1_post", 8);

    // 2: single held up press, released before edge 25.
    for (int e = 0; e <= 40; e++) begin
      btn_up = (e < 25);
      tick();
      chk("t2_up", e, up, logic'(e inside {6, 16, 19, 22, 25, 28}));
      chk("t2_down", e, down, 1'b0);
    end
    idle("t2_post", 6);

    // 3: bounce shorter than the debounce window never produces a command.
    for (int e = 0; e < 20; e++) begin
      btn_up = ((e / 2) % 2) == 0;
      tick();
      chk("t3_up", e, up, 1'b0);
      chk("t3_down", e, down, 1'b0);
    end
    idle("t3_post", 10);

    // 4: both held cancels; releasing down leaves a clean up press.
    for (int e = 0; e <= 50; e++) begin
      btn_up   = (e < 38);
      btn_down = (e < 20);
      tick();
      chk("t4_up", e, up, logic'(e inside {26, 36, 39, 42}));
      chk("t4_down", e, down, 1'b0);
    end
    idle("t4_post", 6);

    // 5: up held into repeat, swapped to down at edge 23, down released at 48.
    for (int e = 0; e <= 58; e++) begin
      btn_up   = (e < 23);
      btn_down = (e >= 23) && (e < 48);
      tick();
      chk("t5_up", e, up, logic'(e inside {6, 16, 19, 22, 25, 28}));
      chk("t5_down", e, down, logic'(e inside {30, 40, 43, 46, 49, 52}));
    end
    idle("t5_post", 6);

    // 6: down held into repeat; reset hits right after the edge-19 pulse.
    for (int e = 0; e <= 19; e++) begin
      btn_down = 1'b1;
      tick();
      chk("t6_pre_down", e, down, logic'(e inside {6, 16, 19}));
      chk("t6_pre_up", e, up, 1'b0);
    end
    reset = 1'b0;
    #1;
    chk("t6_async_down", 19, down, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_rst_down", i, down, 1'b0);
      chk("t6_rst_up", i, up, 1'b0);
    end
    reset = 1'b1;
    // Edge R (relative 0) is the first edge after reset releases.
    for (int e = 0; e <= 30; e++) begin
      btn_down = (e < 20);
      tick();
      chk("t6_down", e, down, logic'(e inside {6, 16, 19, 22, 25}));
      chk("t6_up", e, up, 1'b0);
    end
    idle("t6_post", 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
